priority_decoder_2x4: RTL
=========================

Name: priority_decoder_2x4

Overview:
- Sequential 2-to-4 decoder; the receive-side counterpart of the team's 4x2 priority encoder.
- Accepts a 2-bit encoded index through a valid/ready handshake.
- Drives the matching one-hot line on y for a fixed number of cycles, then returns y to zero.
- Sits downstream of an encoder to regenerate a one-hot strobe, e.g. a grant or a select.

Parameters:
- HOLD_CYCLES, 4, number of cycles the one-hot output stays asserted per accepted code; legal range 1..255.
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- e  input  1  active-high enable; when low, no code is accepted and any hold in progress is aborted.
- in_valid  input  1  in_code is valid this cycle.
- in_code  input  2  encoded index; 2'b11 selects y[3] and 2'b00 selects y[0].
- in_ready  output  1  decoder can accept a code this cycle.
- y  output  4  registered one-hot output, 4'b0000 when idle.
- busy  output  1  high while in HOLD.
- done  output  1  one-cycle pulse, high during the final asserted cycle of a hold.

Behaviour:
- Single clock domain; all outputs are registered except in_ready.
- Reset: y=4'b0000, busy=0, done=0, state=IDLE, counter=0.
  - in_ready is 0 while rst is high.
  - Reset overrides all other inputs in the same cycle, including mid-hold.
- States:
  - IDLE: y=0; in_ready = e.
  - HOLD: y = 1<<code_q; in_ready = 0, except in the repeat case under Optional Feature.
- Handshake:
  - A transfer occurs on the rising edge where in_valid && in_ready.
  - in_code is sampled on that edge and stored in code_q.
  - in_valid with in_ready low has no effect; the source holds the code.
- Latency: code accepted at edge N → y one-hot from edge N to edge N+HOLD_CYCLES, i.e. exactly HOLD_CYCLES clock cycles.
- Counter:
  - Loaded with HOLD_CYCLES on accept.
  - Decrements each HOLD cycle.
  - done=1 and busy=1 during the cycle where counter==1.
  - At the next edge: state→IDLE, y→0, done→0, busy→0.
- Back-to-back transfers (no feature): IDLE lasts at least one cycle, so y is 0 for at least one cycle between consecutive codes. Maximum throughput is one code per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES==1:
  - y is high for one cycle.
  - done is high in that same cycle.
- Enable drop:
  - e=0 in any HOLD cycle → next edge: y=0, busy=0, state=IDLE, no done pulse.
  - e=0 in IDLE → in_ready=0.
- Simultaneous rst and in_valid: rst wins; nothing is accepted.
- Widths: the counter never underflows. HOLD_CYCLES=0 is illegal and is clamped to 1 at elaboration.

Optional Feature:
- Macro: DECODER_REPEAT_EN.
- Defined:
  - During the final HOLD cycle (counter==1), in_ready = e && in_valid && (in_code==code_q).
  - An accept in that cycle reloads the counter with HOLD_CYCLES and keeps state HOLD, so y stays asserted with no gap.
  - done still pulses in the final cycle of each hold period.
  - A different code in that cycle is not accepted; it waits for IDLE.
- Not defined: in_ready=0 throughout HOLD, and a one-cycle zero gap always separates holds.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0, e=1, in_valid=0 → y=0000, busy=0, done=0, in_ready=1.
- Single decode, HOLD_CYCLES=4: in_code=2'b10 accepted at edge N → y=0100 for 4 cycles, done=1 in the 4th cycle only, then y=0000, in_ready=1.
- All codes: send 00, 01, 10, 11 back-to-back with in_valid held high → y sequence 0001, 0010, 0100, 1000.
  - Each asserted for 4 cycles, separated by one 0000 cycle.
  - With DECODER_REPEAT_EN defined, the result is identical because the codes differ.
- Abort: accept 2'b11, drop e at the 2nd hold cycle → next edge y=0000, busy=0, no done pulse. Code 2'b01 is accepted only once e=1 again.
- Reset mid-hold: rst=1 in the 3rd cycle of a hold → next edge y=0000, done=0, state IDLE. An in_valid asserted in the same cycle is not accepted.
- Repeat (DECODER_REPEAT_EN defined): in_code=2'b01 with in_valid held high for 2 transfers → y=0010 for 8 contiguous cycles, done pulses in cycles 4 and 8. Without the macro, a single 0000 cycle appears after cycle 4.

Source files
------------

// File: rtl/priority_decoder_2x4_if.sv
// Handshake and output bundle for priority_decoder_2x4.
// The master side sources codes; the slave side is the decoder.
interface priority_decoder_2x4_if;
  logic       e;
  logic       in_valid;
  logic [1:0] in_code;
  logic       in_ready;
  logic [3:0] y;
  logic       busy;
  logic       done;

  modport master (
    output e,
    output in_valid,
    output in_code,
    input  in_ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  e,
    input  in_valid,
    input  in_code,
    output in_ready,
    output y,
    output busy,
    output done
  );
endinterface

// File: rtl/priority_decoder_2x4.sv
// Sequential 2-to-4 decoder: holds a one-hot line for HOLD_CYCLES cycles per accepted code.
// Define DECODER_REPEAT_EN to allow gap-free re-acceptance of the same code in the final cycle.
module priority_decoder_2x4 #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input logic                   clk,
  input logic                   rst,
  priority_decoder_2x4_if.slave dec_if
);

  // A zero hold is meaningless; treat it as a single-cycle strobe.
  localparam int unsigned      HoldEff  = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HoldEff);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [3:0]       y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             in_ready;
  logic             accept;
  logic [CNT_W-1:0] cnt_dec;

  function automatic logic [3:0] onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: in_ready = dec_if.e;
        StHold: begin
`ifdef DECODER_REPEAT_EN
          in_ready = dec_if.e && dec_if.in_valid && (cnt_q == CntOne) &&
                     (dec_if.in_code == code_q);
`else
          in_ready = 1'b0;
`endif
        end
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept  = dec_if.in_valid && in_ready;
  assign cnt_dec = cnt_q - CntOne;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
          code_d  = dec_if.in_code;
          y_d     = onehot(dec_if.in_code);
          busy_d  = 1'b1;
          done_d  = (HoldLoad == CntOne);
        end else begin
          cnt_d  = '0;
          y_d    = 4'b0000;
          busy_d = 1'b0;
        end
      end
      StHold: begin
        if (!dec_if.e) begin
          // Abort: drop the strobe immediately with no done pulse.
          state_d = StIdle;
          cnt_d   = '0;
          y_d     = 4'b0000;
          busy_d  = 1'b0;
        end else if (accept) begin
          cnt_d  = HoldLoad;
          done_d = (HoldLoad == CntOne);
        end else if (cnt_q <= CntOne) begin
          state_d = StIdle;
          cnt_d   = '0;
          y_d     = 4'b0000;
          busy_d  = 1'b0;
        end else begin
          cnt_d  = cnt_dec;
          done_d = (cnt_dec == CntOne);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        y_d     = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      code_q  <= 2'b00;
      y_q     <= 4'b0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dec_if.in_ready = in_ready;
  assign dec_if.y        = y_q;
  assign dec_if.busy     = busy_q;
  assign dec_if.done     = done_q;

endmodule
